rxll_frame_sched: RTL and testbench
===================================

// Module: rxll_frame_sched
// PURPOSE
//  Read-side frame scheduler for the SATA RX link-layer FIFO (36-bit FWFT, EOF-ready flag).
//  Decides when a frame may start draining, pops it word-by-word onto a valid/ready stream
//  towards the transport layer, and checks framing and length. On abort or error it discards
//  the rest of the frame, then reports length, FIS type and error flags per frame.
// PARAMETERS
//  C_MAX_WORDS   2049  max dwords per frame (data FIS 2048 + header); longer frame => length error
//  C_LEN_W       12    width of frame length counter / frm_len
//  C_CUT_THRU    0     1: frame may start before EOF is buffered, once fifo_rd_count >= C_CUT_THRESH
//  C_CUT_THRESH  256   cut-through start threshold in dwords
// PORTS
//  clk           in   1        single clock (FIFO read clock)
//  rst_n         in   1        async active-low reset
//  enable        in   1        1: new frames may start; frame in flight always completes
//  abort         in   1        sync pulse: discard current/next frame through its EOF
//  fifo_do       in   36       FWFT head word: [31:0] data, [33] SOF, [34] EOF, [35] link err
//  fifo_empty    in   1        FIFO empty
//  fifo_eof_rdy  in   1        at least one complete frame buffered
//  fifo_rd_count in   10       FIFO read-side occupancy
//  fifo_rd_en    out  1        pop head word
//  m_data        out  32       stream data (= fifo_do[31:0])
//  m_valid       out  1        stream valid
//  m_ready       in   1        stream ready
//  m_sof / m_eof out  1        first / last word of frame
//  frm_done      out  1        1-cycle pulse: frame finished (forwarded or discarded)
//  frm_len       out  C_LEN_W  dwords popped for finished frame, held until next frm_done
//  frm_type      out  8        first dword[7:0] (FIS type), held
//  frm_err       out  4        [0] length [1] SOF missing/stray [2] link err seen [3] aborted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters/flags cleared. Clock and reset fixed as above.
//  States IDLE -> XFER -> DONE -> IDLE; IDLE/XFER -> DRAIN -> DONE.
//  IDLE: start when enable & !fifo_empty & (fifo_eof_rdy | (C_CUT_THRU & rd_count>=C_CUT_THRESH)).
//   Head has SOF -> XFER. Head lacks SOF -> DRAIN, err[1] set. abort in IDLE -> arm DRAIN at next start.
//  XFER: m_valid = !fifo_empty (combinational, zero latency); fifo_rd_en = m_valid & m_ready.
//   m_sof = (len==0); m_eof = fifo_do[34] | forced. Each pop: len++; err[2] |= fifo_do[35].
//   First pop latches frm_type. SOF on non-first word: err[1] set, word forwarded as data.
//   Pop with EOF -> DONE. Pop number C_MAX_WORDS without EOF: m_eof forced 1 on that word,
//   err[0] set, -> DRAIN. fifo_empty mid-frame: m_valid=0, wait (no timeout).
//  DRAIN: fifo_rd_en = !fifo_empty, m_valid=0; len keeps counting; pop with EOF -> DONE.
//  abort in XFER: -> DRAIN same edge, err[3] set; downstream sees no m_eof (consumer discards).
//  abort in DRAIN/DONE ignored. abort and EOF pop same cycle: EOF wins, frame clean, err[3]=0.
//  DONE: one cycle; registers frm_len/type/err, pulses frm_done, clears internal counters.
//   Mandatory gap: no pop in DONE, so fifo_eof_rdy settles before the next start decision.
//  SOF+EOF in one word: len=1, m_sof=m_eof=1. len saturates at 2^C_LEN_W-1 in DRAIN.
// CONFIGURATION
//  Macro RXLL_SCHED_STATS_EN defined: adds ports stat_clr (in,1), stat_frames (out,16),
//   stat_errs (out,16): saturating counts of frm_done and of frm_done with frm_err!=0;
//   stat_clr zeroes both (clear wins over same-cycle increment); reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared include rxll_defs.vh: RXLL_DATA_MSB=31, RXLL_SOF_BIT=33, RXLL_EOF_BIT=34,
//   RXLL_ERR_BIT=35, state encodings, frm_err bit indices (shared with rxll_fifo users).
//  One sub-module: rxll_sched_stats (stat counters, instantiated only under RXLL_SCHED_STATS_EN).
// TESTING
//  3-word frame (SOF,D,EOF), m_ready=1 -> 3 back-to-back pops, m_sof on w0, m_eof on w2,
//   frm_done 1 cycle later, frm_len=3, frm_type=fifo_do[7:0] of w0 (e.g. 8'h46), frm_err=0.
//  Same frame, m_ready toggling 1/0 -> pops only on ready cycles, data order intact, frm_len=3.
//  C_MAX_WORDS=4, 6-word frame -> 4 words forwarded, m_eof forced on 4th, 2 drained,
//   frm_len=6, frm_err=4'b0001.
//  Head word without SOF followed by EOF word -> nothing forwarded, frm_len=2, frm_err=4'b0010.
//  abort after 2nd of 5 words -> 3 words drained, no m_eof, frm_len=5, frm_err=4'b1000;
//   next frame forwards cleanly. Also rst_n low mid-XFER -> outputs 0, state IDLE immediately.
//  STATS_EN: 3 frames, one with err -> stat_frames=3, stat_errs=1; stat_clr -> both 0.

Source files
------------

// File: rtl/rxll_frame_sched_pkg.sv
// Shared definitions for the RX link-layer frame scheduler: FIFO word layout,
// scheduler state encoding and frame error flag positions.
package rxll_frame_sched_pkg;

  // 36-bit FWFT FIFO word layout: [31:0] data, [33] SOF, [34] EOF, [35] link error
  localparam int RXLL_DATA_MSB = 31;
  localparam int RXLL_SOF_BIT  = 33;
  localparam int RXLL_EOF_BIT  = 34;
  localparam int RXLL_ERR_BIT  = 35;
  localparam int RXLL_WORD_W   = 36;

  // frm_err bit positions
  localparam int ERR_LEN   = 0;
  localparam int ERR_SOF   = 1;
  localparam int ERR_LINK  = 2;
  localparam int ERR_ABORT = 3;
  localparam int ERR_W     = 4;

  // statistics counter width
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rxll_sched_stats.sv
// Per-frame statistics for rxll_frame_sched: saturating counts of finished
// frames and of finished frames carrying any error flag. Present only when
// RXLL_SCHED_STATS_EN is defined.
`ifdef RXLL_SCHED_STATS_EN
module rxll_sched_stats
  import rxll_frame_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stat_clr_i,
  input  logic              frm_done_i,
  input  logic [ERR_W-1:0]  frm_err_i,
  output logic [STAT_W-1:0] stat_frames_o,
  output logic [STAT_W-1:0] stat_errs_o
);

  logic [STAT_W-1:0] frames_q, frames_d;
  logic [STAT_W-1:0] errs_q, errs_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Next counts: clear has priority over a same-cycle frame report
  always_comb begin
    frames_d = frames_q;
    errs_d   = errs_q;
    if (stat_clr_i) begin
      frames_d = '0;
      errs_d   = '0;
    end else if (frm_done_i) begin
      frames_d = sat_inc(frames_q);
      if (|frm_err_i) errs_d = sat_inc(errs_q);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      errs_q   <= '0;
    end else begin
      frames_q <= frames_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_errs_o   = errs_q;

endmodule
`endif

// File: rtl/rxll_frame_sched.sv
// Read-side frame scheduler for the SATA RX link-layer FIFO. Starts a frame
// once it is fully buffered (or past the cut-through threshold), forwards it
// on a valid/ready stream, discards the remainder after abort/overlength/
// missing SOF, and reports length, FIS type and error flags per frame.
// Optional statistics counters: define RXLL_SCHED_STATS_EN.
module rxll_frame_sched
  import rxll_frame_sched_pkg::*;
#(
  parameter int C_MAX_WORDS  = 2049,
  parameter int C_LEN_W      = 12,
  parameter int C_CUT_THRU   = 0,
  parameter int C_CUT_THRESH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               abort,
  input  logic [35:0]        fifo_do,
  input  logic               fifo_empty,
  input  logic               fifo_eof_rdy,
  input  logic [9:0]         fifo_rd_count,
  output logic               fifo_rd_en,
  output logic [31:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sof,
  output logic               m_eof,
  output logic               frm_done,
  output logic [C_LEN_W-1:0] frm_len,
  output logic [7:0]         frm_type,
  output logic [3:0]         frm_err
`ifdef RXLL_SCHED_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_frames,
  output logic [15:0]        stat_errs
`endif
);

  localparam logic [C_LEN_W-1:0] LastLen = C_LEN_W'(C_MAX_WORDS - 1);

  sched_state_e       state_q, state_d;
  logic [C_LEN_W-1:0] len_q, len_d;
  logic [7:0]         type_q, type_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               arm_q, arm_d;
  logic               done_q;
  logic [C_LEN_W-1:0] frm_len_q;
  logic [7:0]         frm_type_q;
  logic [ERR_W-1:0]   frm_err_q;

  logic head_sof, head_eof, head_lerr, cut_ok, start, at_limit, finish;
  logic unused_bit32;

  // Length counter saturates rather than wrapping on very long drained frames
  function automatic logic [C_LEN_W-1:0] len_inc(input logic [C_LEN_W-1:0] v);
    return (&v) ? v : v + C_LEN_W'(1);
  endfunction

  assign head_sof     = fifo_do[RXLL_SOF_BIT];
  assign head_eof     = fifo_do[RXLL_EOF_BIT];
  assign head_lerr    = fifo_do[RXLL_ERR_BIT];
  assign unused_bit32 = fifo_do[32];
  assign cut_ok   = (C_CUT_THRU != 0) && (int'(fifo_rd_count) >= C_CUT_THRESH);
  assign start    = enable & ~fifo_empty & (fifo_eof_rdy | cut_ok);
  assign at_limit = (len_q == LastLen);

  // Next-state, stream handshake and per-frame bookkeeping
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    type_d     = type_q;
    err_d      = err_q;
    arm_d      = arm_q;
    finish     = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_sof      = 1'b0;
    m_eof      = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // an abort seen while idle discards the next frame to start
        arm_d = arm_q | abort;
        if (start) begin
          arm_d              = 1'b0;
          err_d              = '0;
          err_d[ERR_ABORT]   = arm_q | abort;
          err_d[ERR_SOF]     = ~head_sof;
          state_d = (arm_q | abort | ~head_sof) ? ST_DRAIN : ST_XFER;
        end
      end
      ST_XFER: begin
        m_valid    = ~fifo_empty;
        m_data     = fifo_do[RXLL_DATA_MSB:0];
        m_sof      = m_valid & (len_q == '0);
        m_eof      = m_valid & (head_eof | at_limit);
        fifo_rd_en = m_valid & m_ready;
        if (fifo_rd_en) begin
          len_d = len_inc(len_q);
          if (len_q == '0) type_d = fifo_do[7:0];
          else if (head_sof) err_d[ERR_SOF] = 1'b1;
          if (head_lerr) err_d[ERR_LINK] = 1'b1;
        end
        // a real EOF popped in the same cycle as abort completes the frame cleanly
        if (fifo_rd_en & head_eof) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (fifo_rd_en & at_limit) begin
            err_d[ERR_LEN] = 1'b1;
            state_d        = ST_DRAIN;
          end
          if (abort) begin
            err_d[ERR_ABORT] = 1'b1;
            state_d          = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        fifo_rd_en = ~fifo_empty;
        if (fifo_rd_en) begin
          len_d = len_inc(len_q);
          if (head_eof) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        // ST_DONE: single gap cycle with no pop so fifo_eof_rdy settles
        state_d = ST_IDLE;
        len_d   = '0;
        type_d  = '0;
        err_d   = '0;
      end
    endcase
  end

  // State, frame accumulators and held per-frame report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      type_q     <= '0;
      err_q      <= '0;
      arm_q      <= 1'b0;
      done_q     <= 1'b0;
      frm_len_q  <= '0;
      frm_type_q <= '0;
      frm_err_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      type_q  <= type_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
      done_q  <= finish;
      if (finish) begin
        frm_len_q  <= len_d;
        frm_type_q <= type_d;
        frm_err_q  <= err_d;
      end
    end
  end

  assign frm_done = done_q;
  assign frm_len  = frm_len_q;
  assign frm_type = frm_type_q;
  assign frm_err  = frm_err_q;

`ifdef RXLL_SCHED_STATS_EN
  rxll_sched_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .stat_clr_i    (stat_clr),
    .frm_done_i    (done_q),
    .frm_err_i     (frm_err_q),
    .stat_frames_o (stat_frames),
    .stat_errs_o   (stat_errs)
  );
`endif

endmodule

// File: tb/tb_rxll_frame_sched.sv
// Self-checking bench for rxll_frame_sched (C_MAX_WORDS=4, C_LEN_W=3 so the
// overlength and length-saturation boundaries are reachable with short frames).
module tb_rxll_frame_sched;
  localparam int MAXW    = 4;
  localparam int LW      = 3;
  localparam int LEN_SAT = (1 << LW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [35:0] fifo_do = '0;
  logic fifo_empty = 1'b1, fifo_eof_rdy = 1'b0;
  logic [9:0] fifo_rd_count = '0;
  logic fifo_rd_en, m_valid, m_sof, m_eof, frm_done;
  logic [31:0] m_data;
  logic [LW-1:0] frm_len;
  logic [7:0] frm_type;
  logic [3:0] frm_err;
`ifdef RXLL_SCHED_STATS_EN
  logic stat_clr = 1'b0;
  logic [15:0] stat_frames, stat_errs;
`endif

  rxll_frame_sched #(.C_MAX_WORDS(MAXW), .C_LEN_W(LW), .C_CUT_THRU(0), .C_CUT_THRESH(256)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_eof_rdy(fifo_eof_rdy),
    .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .frm_done(frm_done),
    .frm_len(frm_len), .frm_type(frm_type), .frm_err(frm_err)
`ifdef RXLL_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_frames(stat_frames), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [35:0] fq[$];     // FIFO contents, head at index 0
  logic [33:0] beats[$];  // accepted stream beats {eof, sof, data}

  // reference model: frame phase 0 idle, 1 forwarding, 2 discarding, 3 report cycle
  int mph = 0, mlen = 0, marm = 0;
  logic [3:0] merr = '0;
  logic [7:0] mtype = '0;
  logic [LW-1:0] exp_len = '0;
  logic [7:0] exp_type = '0;
  logic [3:0] exp_err = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] mkw(input logic lerr, input logic eof, input logic sof,
                                      input logic [31:0] d);
    return {lerr, eof, sof, 1'b0, d};
  endfunction

  task automatic refresh();
    int ne = 0;
    foreach (fq[i]) if (fq[i][34]) ne++;
    fifo_empty    = (fq.size() == 0);
    fifo_do       = fifo_empty ? {4'($urandom), 32'($urandom)} : fq[0];
    fifo_eof_rdy  = (ne > 0);
    fifo_rd_count = 10'(fq.size());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic push_frame(input int n, input logic [7:0] ftype, input logic sof0);
    for (int i = 0; i < n; i++)
      fq.push_back(mkw(1'b0, i == n - 1, (i == 0) ? sof0 : 1'b0,
                       (i == 0) ? {24'hABCD00, ftype} : 32'h1000_0000 + 32'(i)));
    refresh();
  endtask

  task automatic push_random_frame();
    int n = $urandom_range(1, 9);
    for (int i = 0; i < n; i++)
      fq.push_back(mkw($urandom_range(0, 15) == 0, i == n - 1,
                       (i == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0),
                       $urandom));
    refresh();
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (!frm_done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({nm, "_done"}, frm_done, 1'b1);
  endtask

  // Compare process: mid-cycle, predict this cycle's outputs from the frame rules
  always @(negedge clk) begin : cmp
    logic valid_e, pop_e, forced, fin;
    if (!rst_n) begin
      mph = 0; mlen = 0; marm = 0; merr = '0; mtype = '0;
      exp_len = '0; exp_type = '0; exp_err = '0;
    end else begin
      valid_e = (mph == 1) && !fifo_empty;
      pop_e   = (mph == 1) ? (valid_e && m_ready) : (mph == 2) ? !fifo_empty : 1'b0;
      forced  = (mph == 1) && (mlen == MAXW - 1);
      chk("m_valid", m_valid, valid_e);
      chk("fifo_rd_en", fifo_rd_en, pop_e);
      chk("frm_done", frm_done, mph == 3);
      chk("frm_len", frm_len, exp_len);
      chk("frm_type", frm_type, exp_type);
      chk("frm_err", frm_err, exp_err);
      if (valid_e) begin
        chk("m_data", m_data, fifo_do[31:0]);
        chk("m_sof", m_sof, mlen == 0);
        chk("m_eof", m_eof, fifo_do[34] || forced);
      end
      fin = 1'b0;
      case (mph)
        0: begin
          if (abort) marm = 1;
          if (enable && !fifo_empty && fifo_eof_rdy) begin
            merr = '0;
            merr[3] = (marm != 0);
            merr[1] = !fifo_do[33];
            mph = (marm != 0 || !fifo_do[33]) ? 2 : 1;
            marm = 0;
          end
        end
        1: begin
          if (pop_e) begin
            if (mlen == 0) mtype = fifo_do[7:0];
            else if (fifo_do[33]) merr[1] = 1'b1;
            if (fifo_do[35]) merr[2] = 1'b1;
            mlen++;
          end
          if (pop_e && fifo_do[34]) fin = 1'b1;
          else begin
            if (pop_e && forced) begin merr[0] = 1'b1; mph = 2; end
            if (abort) begin merr[3] = 1'b1; mph = 2; end
          end
        end
        2: if (pop_e) begin
          mlen++;
          if (fifo_do[34]) fin = 1'b1;
        end
        default: begin mph = 0; mlen = 0; merr = '0; mtype = '0; end
      endcase
      if (fin) begin
        mph = 3;
        exp_len = LW'((mlen > LEN_SAT) ? LEN_SAT : mlen);
        exp_type = mtype;
        exp_err = merr;
      end
      if (m_valid && m_ready) beats.push_back({m_eof, m_sof, m_data});
      if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    refresh();
    tick(); tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_frm_done", frm_done, 1'b0);
    chk("rst_frm_len", frm_len, 3'd0);
    chk("rst_frm_err", frm_err, 4'd0);
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    tick();

    // 3-word frame, ready always high: 3 pops, report 4 cycles after it is buffered
    beats.delete();
    push_frame(3, 8'h46, 1'b1);
    wait_done("t1", cyc);
    chk("t1_latency", cyc, 4);
    chk("t1_len", frm_len, 3'd3);
    chk("t1_type", frm_type, 8'h46);
    chk("t1_err", frm_err, 4'b0000);
    chk("t1_beats", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("t1_w0", beats[0], {2'b01, 32'hABCD0046});
      chk("t1_w1", beats[1], {2'b00, 32'h10000001});
      chk("t1_w2", beats[2], {2'b10, 32'h10000002});
    end
    tick();

    // same frame with ready toggling
    beats.delete();
    push_frame(3, 8'h46, 1'b1);
    m_ready = 1'b0; cyc = 0;
    while (!frm_done && cyc < 40) begin
      tick();
      m_ready = !m_ready;
      cyc++;
    end
    m_ready = 1'b1;
    chk("t2_done", frm_done, 1'b1);
    chk("t2_len", frm_len, 3'd3);
    chk("t2_beats", beats.size(), 3);
    if (beats.size() == 3) chk("t2_order", {beats[0][31:0], beats[2][31:0]}, {32'hABCD0046, 32'h10000002});
    tick();

    // 6-word frame over a 4-word limit: 4 forwarded, EOF forced on 4th, 2 drained
    beats.delete();
    push_frame(6, 8'h34, 1'b1);
    wait_done("t3", cyc);
    chk("t3_len", frm_len, 3'd6);
    chk("t3_err", frm_err, 4'b0001);
    chk("t3_beats", beats.size(), 4);
    if (beats.size() == 4) chk("t3_last", beats[3], {2'b10, 32'h10000003});
    tick();

    // head without SOF then EOF word: nothing forwarded
    beats.delete();
    push_frame(2, 8'h46, 1'b0);
    wait_done("t4", cyc);
    chk("t4_len", frm_len, 3'd2);
    chk("t4_err", frm_err, 4'b0010);
    chk("t4_type", frm_type, 8'h00);
    chk("t4_beats", beats.size(), 0);
    tick();

    // abort together with the 2nd pop of a 5-word frame
    beats.delete();
    push_frame(5, 8'h46, 1'b1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t5", cyc);
    chk("t5_len", frm_len, 3'd5);
    chk("t5_err", frm_err, 4'b1000);
    chk("t5_beats", beats.size(), 2);
    if (beats.size() == 2) chk("t5_no_eof", beats[1][33], 1'b0);
    tick();
    beats.delete();
    push_frame(3, 8'h27, 1'b1);
    wait_done("t5b", cyc);
    chk("t5b_err", frm_err, 4'b0000);
    chk("t5b_type", frm_type, 8'h27);
    chk("t5b_beats", beats.size(), 3);
    tick();

    // 9-word frame: length saturates at 7
    beats.delete();
    push_frame(9, 8'h46, 1'b1);
    wait_done("t6", cyc);
    chk("t6_len", frm_len, 3'd7);
    chk("t6_err", frm_err, 4'b0001);
    chk("t6_beats", beats.size(), 4);
    tick();

    // abort while idle and empty discards the next frame
    beats.delete();
    enable = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; enable = 1'b1;
    push_frame(2, 8'h46, 1'b1);
    wait_done("t7", cyc);
    chk("t7_len", frm_len, 3'd2);
    chk("t7_err", frm_err, 4'b1000);
    chk("t7_beats", beats.size(), 0);
    tick();

    // asynchronous reset in the middle of a transfer
    push_frame(5, 8'h46, 1'b1);
    tick();
    tick();
    chk("t8_pre_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t8_valid", m_valid, 1'b0);
    chk("t8_rd_en", fifo_rd_en, 1'b0);
    chk("t8_sof", m_sof, 1'b0);
    chk("t8_data", m_data, 32'h0);
    chk("t8_len", frm_len, 3'd0);
    chk("t8_err", frm_err, 4'd0);
    fq.delete();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef RXLL_SCHED_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st_clr0", stat_frames, 16'd0);
    push_frame(3, 8'h46, 1'b1);
    push_frame(2, 8'h46, 1'b0);
    push_frame(1, 8'h46, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    chk("st_frames", stat_frames, 16'd3);
    chk("st_errs", stat_errs, 16'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st_frames_clr", stat_frames, 16'd0);
    chk("st_errs_clr", stat_errs, 16'd0);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 15) != 0);
      abort   = ($urandom_range(0, 40) == 0);
      if (fq.size() < 12 && $urandom_range(0, 3) == 0) push_random_frame();
    end
    abort = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 400 && (fq.size() != 0 || mph != 0); i++) tick();
    chk("final_fifo_drained", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
